// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci/Galois LFSR with step enable, parallel load,
// all-zero lock-up recovery, sequence-wrap detection and a measured period.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   en           advance one step this cycle
//   load         parallel load of din (wins over en)
//   din          load value
//   q            current state (registered)
//   bit_out      serial output, q[WIDTH-1]
//   wrap         one-cycle pulse, state has just returned to the reference value
//   lockup       one-cycle pulse, an all-zero state was recovered to SEED
//   period       length of the last completed sequence (saturating)
//   period_valid period holds a measurement since the last load/reset/recovery
module lfsr_gen #(
    parameter int unsigned       WIDTH = 26,
    parameter int unsigned       MODE  = 0,
    parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(26'h2000023),
    parameter logic [WIDTH-1:0]  SEED  = WIDTH'(1),
    parameter int unsigned       CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             bit_out,
    output logic             wrap,
    output logic             lockup,
    output logic [CNT_W-1:0] period,
    output logic             period_valid
);

    logic [WIDTH-1:0] ref_q;
    logic [CNT_W-1:0] step_cnt;
    logic [WIDTH-1:0] next_q;
    logic [CNT_W-1:0] cnt_inc;

    // Step function, selected at elaboration time
    generate
        if (MODE == 0) begin : g_fib
            always_comb begin
                next_q = {q[WIDTH-2:0], ^(q & TAPS)};
            end
        end else begin : g_gal
            always_comb begin
                next_q = {q[WIDTH-2:0], 1'b0} ^ (q[WIDTH-1] ? TAPS : '0);
            end
        end
    endgenerate

    // Saturating increment shared by the step counter and the period capture
    always_comb begin
        cnt_inc = (&step_cnt) ? step_cnt : step_cnt + CNT_W'(1);
    end

    assign bit_out = q[WIDTH-1];

    // State, reference and measurement registers; priority load > lock-up > step > hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q            <= SEED;
            ref_q        <= SEED;
            step_cnt     <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            wrap         <= 1'b0;
            lockup       <= 1'b0;
        end else begin
            wrap   <= 1'b0;
            lockup <= 1'b0;
            if (load) begin
                q            <= din;
                ref_q        <= din;
                step_cnt     <= '0;
                period_valid <= 1'b0;
            end else if (en) begin
                if (q == '0) begin
                    // All-zero is a fixed point of the XOR network; restart from SEED
                    q            <= SEED;
                    ref_q        <= SEED;
                    step_cnt     <= '0;
                    period_valid <= 1'b0;
                    lockup       <= 1'b1;
                end else begin
                    q <= next_q;
                    if (next_q == ref_q) begin
                        wrap         <= 1'b1;
                        period       <= cnt_inc;
                        period_valid <= 1'b1;
                        step_cnt     <= '0;
                    end else begin
                        step_cnt <= cnt_inc;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: 4-bit Fibonacci and Galois sequences, lock-up
// recovery, load/en priority, 26-bit default configuration, counter saturation
// and asynchronous reset.
module tb_lfsr_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 4-bit Fibonacci, TAPS=C
    logic        f_en, f_load, f_bit, f_wrap, f_lock, f_pv;
    logic [3:0]  f_din, f_q;
    logic [31:0] f_per;
    // 4-bit Galois, TAPS=3
    logic        g_en, g_load, g_bit, g_wrap, g_lock, g_pv;
    logic [3:0]  g_din, g_q;
    logic [31:0] g_per;
    // default 26-bit configuration
    logic        d_en, d_load, d_bit, d_wrap, d_lock, d_pv;
    logic [25:0] d_din, d_q;
    logic [31:0] d_per;
    // 4-bit Fibonacci with a 3-bit counter
    logic        s_en, s_load, s_bit, s_wrap, s_lock, s_pv;
    logic [3:0]  s_din, s_q;
    logic [2:0]  s_per;

    lfsr_gen #(.WIDTH(4), .MODE(0), .TAPS(4'hC), .SEED(4'h1), .CNT_W(32)) u_fib (
        .clk(clk), .rst_n(rst_n), .en(f_en), .load(f_load), .din(f_din),
        .q(f_q), .bit_out(f_bit), .wrap(f_wrap), .lockup(f_lock),
        .period(f_per), .period_valid(f_pv));

    lfsr_gen #(.WIDTH(4), .MODE(1), .TAPS(4'h3), .SEED(4'h1), .CNT_W(32)) u_gal (
        .clk(clk), .rst_n(rst_n), .en(g_en), .load(g_load), .din(g_din),
        .q(g_q), .bit_out(g_bit), .wrap(g_wrap), .lockup(g_lock),
        .period(g_per), .period_valid(g_pv));

    lfsr_gen u_def (
        .clk(clk), .rst_n(rst_n), .en(d_en), .load(d_load), .din(d_din),
        .q(d_q), .bit_out(d_bit), .wrap(d_wrap), .lockup(d_lock),
        .period(d_per), .period_valid(d_pv));

    lfsr_gen #(.WIDTH(4), .MODE(0), .TAPS(4'hC), .SEED(4'h1), .CNT_W(3)) u_sat (
        .clk(clk), .rst_n(rst_n), .en(s_en), .load(s_load), .din(s_din),
        .q(s_q), .bit_out(s_bit), .wrap(s_wrap), .lockup(s_lock),
        .period(s_per), .period_valid(s_pv));

    logic [3:0] fib_seq [15] = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                                 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
    logic [3:0] gal_seq [15] = '{4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB, 4'h5,
                                 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h1};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Taps 25,5,1,0 of the default polynomial
    function automatic logic [25:0] model_step(input logic [25:0] s);
        logic fb;
        fb = s[25] ^ s[5] ^ s[1] ^ s[0];
        return {s[24:0], fb};
    endfunction

    logic [25:0] model;

    initial begin
        rst_n = 1'b0;
        f_en = 1'b0; f_load = 1'b0; f_din = '0;
        g_en = 1'b0; g_load = 1'b0; g_din = '0;
        d_en = 1'b0; d_load = 1'b0; d_din = '0;
        s_en = 1'b0; s_load = 1'b0; s_din = '0;
        repeat (2) @(posedge clk);
        #1;

        // reset state
        check("rst q",       64'(f_q),    64'h1);
        check("rst wrap",    64'(f_wrap), 64'h0);
        check("rst lockup",  64'(f_lock), 64'h0);
        check("rst period",  64'(f_per),  64'h0);
        check("rst pvalid",  64'(f_pv),   64'h0);
        check("rst def q",   64'(d_q),    64'h1);
        rst_n = 1'b1;

        // Fibonacci 4-bit full cycle, with the 3-bit-counter copy alongside
        f_en = 1'b1;
        s_en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            check("fib q",      64'(f_q),    64'(fib_seq[i]));
            check("fib bit",    64'(f_bit),  64'(fib_seq[i][3]));
            check("fib wrap",   64'(f_wrap), 64'(i == 14));
            check("sat wrap",   64'(s_wrap), 64'(i == 14));
            if (i < 14) check("sat pvalid pre", 64'(s_pv), 64'h0);
        end
        s_en = 1'b0;
        check("fib period",  64'(f_per), 64'd15);
        check("fib pvalid",  64'(f_pv),  64'h1);
        check("sat period",  64'(s_per), 64'd7);
        check("sat pvalid",  64'(s_pv),  64'h1);
        for (int i = 0; i < 15; i++) begin
            tick();
            check("fib wrap2", 64'(f_wrap), 64'(i == 14));
        end
        check("fib period2", 64'(f_per), 64'd15);
        f_en = 1'b0;

        // Galois 4-bit full cycle
        g_en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            check("gal q",    64'(g_q),    64'(gal_seq[i]));
            check("gal wrap", 64'(g_wrap), 64'(i == 14));
        end
        g_en = 1'b0;
        check("gal period", 64'(g_per), 64'd15);
        check("gal pvalid", 64'(g_pv),  64'h1);

        // load zero, hold, then lock-up recovery
        f_load = 1'b1; f_din = 4'h0;
        tick();
        f_load = 1'b0;
        check("ld0 q",      64'(f_q),    64'h0);
        check("ld0 pvalid", 64'(f_pv),   64'h0);
        check("ld0 period", 64'(f_per),  64'd15);
        check("ld0 lockup", 64'(f_lock), 64'h0);
        repeat (2) tick();
        check("ld0 hold q", 64'(f_q), 64'h0);
        f_en = 1'b1;
        tick();
        check("lk q",      64'(f_q),    64'h1);
        check("lk lockup", 64'(f_lock), 64'h1);
        check("lk wrap",   64'(f_wrap), 64'h0);
        check("lk pvalid", 64'(f_pv),   64'h0);
        tick();
        check("lk next q",  64'(f_q),    64'h2);
        check("lk lockup2", 64'(f_lock), 64'h0);

        // load wins over en; full cycle back to the loaded value
        f_load = 1'b1; f_din = 4'b1011;
        tick();
        f_load = 1'b0;
        check("ld q",      64'(f_q),    64'hB);
        check("ld wrap",   64'(f_wrap), 64'h0);
        check("ld pvalid", 64'(f_pv),   64'h0);
        for (int i = 0; i < 15; i++) begin
            tick();
            if (i == 0) check("ld step q", 64'(f_q), 64'h7);
            check("ld wrap seq", 64'(f_wrap), 64'(i == 14));
        end
        check("ld wrap q",   64'(f_q),   64'hB);
        check("ld period",   64'(f_per), 64'd15);
        check("ld pvalid2",  64'(f_pv),  64'h1);
        f_en = 1'b0;

        // default 26-bit configuration against the reference model
        d_load = 1'b1; d_din = 26'b11011001010110101101011001;
        tick();
        d_load = 1'b0;
        model = 26'b11011001010110101101011001;
        check("def ld q", 64'(d_q), 64'(model));
        d_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            model = model_step(model);
            check("def q",   64'(d_q),   64'(model));
            check("def bit", 64'(d_bit), 64'(model[25]));
        end

        // asynchronous reset between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        check("arst def q",      64'(d_q),  64'h1);
        check("arst def pvalid", 64'(d_pv), 64'h0);
        check("arst fib pvalid", 64'(f_pv), 64'h0);
        check("arst fib period", 64'(f_per), 64'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post rst step", 64'(d_q), 64'h3);
        d_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
